// File: rtl/traffic_controller_if.sv
// traffic_controller_if
//   Groups the sensor inputs and signal-head outputs of the traffic
//   controller into one bundle.
//
//   Handshake: pedReq/pedAck is a request/acknowledge pair, not a stalling
//   valid/ready pair. The controller samples pedReq on every rising edge, and
//   any 1 latches a pending request, so a one-cycle pulse is enough. A request
//   stays pending until it is serviced. pedAck is a registered one-cycle pulse
//   in the first WALK cycle of that service. The requester never waits on
//   pedAck and may deassert pedReq at any time.
//
//   Signals
//     sideCarPresent  master->slave  side-road vehicle sensor (level)
//     pedReq          master->slave  pedestrian request (pulse or level)
//     mainCarControl  slave->master  main-road head: 0 red, 1 yellow, 2 green
//     sideCarControl  slave->master  side-road head: 0 red, 1 yellow, 2 green
//     walkSignal      slave->master  pedestrian walk lamp
//     pedAck          slave->master  one-cycle service acknowledge
//     stateOut        slave->master  FSM state encoding (debug)
interface traffic_controller_if;
  logic       sideCarPresent;
  logic       pedReq;
  logic [1:0] mainCarControl;
  logic [1:0] sideCarControl;
  logic       walkSignal;
  logic       pedAck;
  logic [2:0] stateOut;

  modport master (
    output sideCarPresent, pedReq,
    input  mainCarControl, sideCarControl, walkSignal, pedAck, stateOut
  );

  modport slave (
    input  sideCarPresent, pedReq,
    output mainCarControl, sideCarControl, walkSignal, pedAck, stateOut
  );
endinterface

// File: rtl/traffic_controller.sv
// traffic_controller
//   Two-road intersection controller with a pedestrian phase. The main road
//   rests on green. Side-road demand, or a latched pedestrian request, ends
//   the main green once MIN_GREEN has elapsed. Every change of right-of-way
//   passes through an all-red clearance state.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; forces ALLRED_B
//     bus    traffic_controller_if.slave (sensor inputs, signal outputs, debug state)
//
//   All timings are in clock cycles, and every parameter must be 1 or more.
//   The car-signal, walk and stateOut outputs are decoded from the state
//   register only. pedAck is a separate register.
module traffic_controller #(
  parameter int MIN_GREEN    = 4,
  parameter int GREEN_TICKS  = 6,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 3
) (
  input logic clk,
  input logic rst_n,
  traffic_controller_if.slave bus
);

  localparam int CW = 16;

  // A timed state of length N loads N-1 on entry and exits on the edge
  // where the counter reads 0.
  localparam logic [CW-1:0] LD_MIN    = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] LD_GREEN  = CW'(GREEN_TICKS - 1);
  localparam logic [CW-1:0] LD_YELLOW = CW'(YELLOW_TICKS - 1);
  localparam logic [CW-1:0] LD_ALLRED = CW'(ALLRED_TICKS - 1);
  localparam logic [CW-1:0] LD_WALK   = CW'(WALK_TICKS - 1);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_A    = 3'd2,
    WALK        = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALLRED_B    = 3'd6
  } state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic          pedPending, pedPendingNext;
  logic          pedAckReg;
  logic          cntZero;
  logic          enterWalk;

  assign cntZero   = (cnt == '0);
  assign enterWalk = (stateNext == WALK) && (state != WALK);

  // A request that arrives on the WALK-entry edge is covered by that walk,
  // so clearing takes priority over setting.
  assign pedPendingNext = enterWalk ? 1'b0 : (bus.pedReq ? 1'b1 : pedPending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ALLRED_B;
      cnt        <= LD_ALLRED;
      pedPending <= 1'b0;
      pedAckReg  <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      pedPending <= pedPendingNext;
      pedAckReg  <= enterWalk;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      MAIN_GREEN: begin
        // After MIN_GREEN the counter parks at 0 until demand appears.
        if (!cntZero) begin
          cntNext = cnt - CW'(1);
        end else if (bus.sideCarPresent || pedPending) begin
          stateNext = MAIN_YELLOW;
          cntNext   = LD_YELLOW;
        end
      end
      MAIN_YELLOW: begin
        if (cntZero) begin
          stateNext = ALLRED_A;
          cntNext   = LD_ALLRED;
        end else begin
          cntNext = cnt - CW'(1);
        end
      end
      ALLRED_A: begin
        if (cntZero) begin
          if (pedPending) begin
            stateNext = WALK;
            cntNext   = LD_WALK;
          end else begin
            stateNext = SIDE_GREEN;
            cntNext   = LD_GREEN;
          end
        end else begin
          cntNext = cnt - CW'(1);
        end
      end
      WALK: begin
        // Both car heads are red during WALK, so either road may follow it
        // directly.
        if (cntZero) begin
          if (bus.sideCarPresent) begin
            stateNext = SIDE_GREEN;
            cntNext   = LD_GREEN;
          end else begin
            stateNext = MAIN_GREEN;
            cntNext   = LD_MIN;
          end
        end else begin
          cntNext = cnt - CW'(1);
        end
      end
      SIDE_GREEN: begin
        if (cntZero) begin
          stateNext = SIDE_YELLOW;
          cntNext   = LD_YELLOW;
        end else begin
          cntNext = cnt - CW'(1);
        end
      end
      SIDE_YELLOW: begin
        if (cntZero) begin
          stateNext = ALLRED_B;
          cntNext   = LD_ALLRED;
        end else begin
          cntNext = cnt - CW'(1);
        end
      end
      ALLRED_B: begin
        if (cntZero) begin
          stateNext = MAIN_GREEN;
          cntNext   = LD_MIN;
        end else begin
          cntNext = cnt - CW'(1);
        end
      end
      default: begin
        // Encoding 7 is unreachable. Recover through a full all-red interval.
        stateNext = ALLRED_B;
        cntNext   = LD_ALLRED;
      end
    endcase
  end

  always_comb begin
    bus.mainCarControl = 2'd0;
    bus.sideCarControl = 2'd0;
    bus.walkSignal     = 1'b0;
    case (state)
      MAIN_GREEN:  bus.mainCarControl = 2'd2;
      MAIN_YELLOW: bus.mainCarControl = 2'd1;
      SIDE_GREEN:  bus.sideCarControl = 2'd2;
      SIDE_YELLOW: bus.sideCarControl = 2'd1;
      WALK:        bus.walkSignal     = 1'b1;
      default: ;
    endcase
  end

  assign bus.stateOut = state;
  assign bus.pedAck   = pedAckReg;

endmodule

// File: tb/tb_traffic_controller.sv
// tb_traffic_controller
//   Directed bench for traffic_controller with default parameters. Each
//   scenario task fills exp_q with the cycle-by-cycle expected output word
//   {stateOut, main, side, walk, pedAck}. It then pops the queue one cycle at
//   a time and compares the outputs inline, 1 time unit after each rising
//   edge. A negedge monitor checks that the two roads are never non-red
//   together and that code 3 never appears.
module tb_traffic_controller;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [8:0] exp_q[$];

  // Expected output words, hand-encoded as {state, main, side, walk, ack}.
  localparam logic [8:0] E_MG  = {3'd0, 2'd2, 2'd0, 1'b0, 1'b0};
  localparam logic [8:0] E_MY  = {3'd1, 2'd1, 2'd0, 1'b0, 1'b0};
  localparam logic [8:0] E_ARA = {3'd2, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [8:0] E_WKA = {3'd3, 2'd0, 2'd0, 1'b1, 1'b1};
  localparam logic [8:0] E_WK  = {3'd3, 2'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [8:0] E_SG  = {3'd4, 2'd0, 2'd2, 1'b0, 1'b0};
  localparam logic [8:0] E_SY  = {3'd5, 2'd0, 2'd1, 1'b0, 1'b0};
  localparam logic [8:0] E_ARB = {3'd6, 2'd0, 2'd0, 1'b0, 1'b0};

  traffic_controller_if bus();

  traffic_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- safety monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if ((bus.mainCarControl != 2'd0 && bus.sideCarControl != 2'd0) ||
          bus.mainCarControl == 2'd3 || bus.sideCarControl == 2'd3) begin
        miscompares++;
        $display("FAIL safety at %0t: main=%0d side=%0d, required at least one red and no code 3",
                 $time, bus.mainCarControl, bus.sideCarControl);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seg(input logic [8:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Holds reset across two edges and releases it 1 unit after an edge.
  // On return the DUT is in its first post-reset ALLRED_B cycle.
  task automatic do_reset(input logic side, input logic ped);
    rst_n = 1'b0;
    bus.sideCarPresent = side;
    bus.pedReq = ped;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [8:0] obs;
    rst_n = 1'b1;
    bus.sideCarPresent = 1'b0;
    bus.pedReq = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      obs = {bus.stateOut, bus.mainCarControl, bus.sideCarControl, bus.walkSignal, bus.pedAck};
      vectors++;
      if (obs !== E_ARB) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got %b, required %b", i, obs, E_ARB);
      end
      step();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    logic [8:0] obs;
    logic [8:0] expv;
    int cyc;
    expect_seg(E_ARB, 1);
    expect_seg(E_MG, 52);
    cyc = 0;
    while (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      obs = {bus.stateOut, bus.mainCarControl, bus.sideCarControl, bus.walkSignal, bus.pedAck};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL idle cycle %0d: got %b, required %b", cyc, obs, expv);
      end
      step();
      cyc++;
    end
  endtask

  task automatic test_side_cycle();
    logic [8:0] obs;
    logic [8:0] expv;
    int cyc;
    do_reset(1'b1, 1'b0);
    expect_seg(E_ARB, 1); expect_seg(E_MG, 4); expect_seg(E_MY, 2);
    expect_seg(E_ARA, 1); expect_seg(E_SG, 6); expect_seg(E_SY, 2);
    expect_seg(E_ARB, 1); expect_seg(E_MG, 1);
    cyc = 0;
    while (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      obs = {bus.stateOut, bus.mainCarControl, bus.sideCarControl, bus.walkSignal, bus.pedAck};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL side_cycle cycle %0d: got %b, required %b", cyc, obs, expv);
      end
      step();
      cyc++;
    end
    bus.sideCarPresent = 1'b0;
  endtask

  // Cycle 1 is the first MAIN_GREEN cycle and always carries a request pulse.
  // extraCyc adds a second pulse: cycle 7 is ALLRED_A, where the pulse is
  // sampled on the WALK-entry edge and must be absorbed. Cycle 9 is inside
  // WALK, where the pulse must be latched for another service.
  task automatic test_ped(input string name, input int extraCyc, input bit second);
    logic [8:0] obs;
    logic [8:0] expv;
    int cyc;
    do_reset(1'b0, 1'b0);
    expect_seg(E_ARB, 1); expect_seg(E_MG, 4); expect_seg(E_MY, 2);
    expect_seg(E_ARA, 1); expect_seg(E_WKA, 1); expect_seg(E_WK, 2);
    if (second) begin
      expect_seg(E_MG, 4); expect_seg(E_MY, 2); expect_seg(E_ARA, 1); expect_seg(E_WKA, 1);
    end else begin
      expect_seg(E_MG, 8);
    end
    cyc = 0;
    while (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      obs = {bus.stateOut, bus.mainCarControl, bus.sideCarControl, bus.walkSignal, bus.pedAck};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %b, required %b", name, cyc, obs, expv);
      end
      bus.pedReq = (cyc == 1) || (cyc == extraCyc);
      step();
      cyc++;
    end
    bus.pedReq = 1'b0;
  endtask

  task automatic test_both_held();
    logic [8:0] obs;
    logic [8:0] expv;
    int cyc;
    do_reset(1'b1, 1'b1);
    expect_seg(E_ARB, 1); expect_seg(E_MG, 4); expect_seg(E_MY, 2);
    expect_seg(E_ARA, 1); expect_seg(E_WKA, 1); expect_seg(E_WK, 2);
    expect_seg(E_SG, 6); expect_seg(E_SY, 2); expect_seg(E_ARB, 1);
    expect_seg(E_MG, 4); expect_seg(E_MY, 2); expect_seg(E_ARA, 1);
    expect_seg(E_WKA, 1);
    cyc = 0;
    while (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      obs = {bus.stateOut, bus.mainCarControl, bus.sideCarControl, bus.walkSignal, bus.pedAck};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL both_held cycle %0d: got %b, required %b", cyc, obs, expv);
      end
      step();
      cyc++;
    end
    bus.sideCarPresent = 1'b0;
    bus.pedReq = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [8:0] obs;
    logic [8:0] expv;
    int cyc;
    do_reset(1'b1, 1'b0);
    expect_seg(E_ARB, 1); expect_seg(E_MG, 4); expect_seg(E_MY, 2);
    expect_seg(E_ARA, 1); expect_seg(E_SG, 3);
    cyc = 0;
    while (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      obs = {bus.stateOut, bus.mainCarControl, bus.sideCarControl, bus.walkSignal, bus.pedAck};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reset_mid_pre cycle %0d: got %b, required %b", cyc, obs, expv);
      end
      // This request is pending when reset hits and must be discarded.
      bus.pedReq = (cyc == 9);
      step();
      cyc++;
    end
    // Now in the fourth SIDE_GREEN cycle. Assert reset between edges.
    #2 rst_n = 1'b0;
    #1;
    obs = {bus.stateOut, bus.mainCarControl, bus.sideCarControl, bus.walkSignal, bus.pedAck};
    vectors++;
    if (obs !== E_ARB) begin
      miscompares++;
      $display("FAIL reset_async: got %b, required %b", obs, E_ARB);
    end
    bus.sideCarPresent = 1'b0;
    step();
    rst_n = 1'b1;
    expect_seg(E_ARB, 1); expect_seg(E_MG, 10);
    cyc = 0;
    while (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      obs = {bus.stateOut, bus.mainCarControl, bus.sideCarControl, bus.walkSignal, bus.pedAck};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reset_mid_post cycle %0d: got %b, required %b", cyc, obs, expv);
      end
      step();
      cyc++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_idle();
    test_side_cycle();
    test_ped("ped_single", -1, 1'b0);
    test_ped("ped_absorb", 7, 1'b0);
    test_ped("ped_in_walk", 9, 1'b1);
    test_both_held();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_controller.md
TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 SHALL have parameter MIN_GREEN, default 4: minimum main-road green time, in clock cycles.
REQ-002 SHALL have parameter GREEN_TICKS, default 6: side-road green time, in cycles.
REQ-003 SHALL have parameter YELLOW_TICKS, default 2: yellow time for either road, in cycles.
REQ-004 SHALL have parameter ALLRED_TICKS, default 1: all-red clearance time, in cycles.
REQ-005 SHALL have parameter WALK_TICKS, default 3: pedestrian walk time, in cycles.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port sideCarPresent, input, 1 bit: side-road vehicle sensor, level-sensitive.
REQ-009 SHALL have port pedReq, input, 1 bit: pedestrian request; a single-cycle pulse is sufficient.
REQ-010 SHALL have port mainCarControl, output, 2 bits: car-signal code for the main road.
REQ-011 SHALL have port sideCarControl, output, 2 bits: car-signal code for the side road.
REQ-012 SHALL have port walkSignal, output, 1 bit: pedestrian walk lamp.
REQ-013 SHALL have port pedAck, output, 1 bit: one-cycle acknowledge that a latched request is being serviced.
REQ-014 SHALL have port stateOut, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-015 Car-signal codes SHALL be 0 = red, 1 = yellow, 2 = green; code 3 SHALL never be driven.
REQ-016 States and stateOut encodings SHALL be MAIN_GREEN=0, MAIN_YELLOW=1, ALLRED_A=2, WALK=3, SIDE_GREEN=4, SIDE_YELLOW=5, ALLRED_B=6; encoding 7 SHALL be unreachable and SHALL recover to ALLRED_B on the next edge.
REQ-017 All outputs except pedAck SHALL be decoded from the state register only, with no combinational path from any input.
REQ-018 mainCarControl SHALL be 2 in MAIN_GREEN, 1 in MAIN_YELLOW, and 0 in every other state.
REQ-019 sideCarControl SHALL be 2 in SIDE_GREEN, 1 in SIDE_YELLOW, and 0 in every other state.
REQ-020 walkSignal SHALL be 1 only in WALK.
REQ-021 On entry to a timed state of length N, a down-counter (width 16 or more) SHALL load N-1; the state SHALL exit on the edge where the counter equals 0, so each timed state lasts exactly N cycles.
REQ-022 All parameters SHALL be 1 or greater.
REQ-023 MAIN_GREEN SHALL last at least MIN_GREEN cycles.
REQ-024 Once MIN_GREEN has expired, MAIN_GREEN SHALL move to MAIN_YELLOW on the first edge where sideCarPresent or pedPending is 1.
REQ-025 With no demand, MAIN_GREEN SHALL remain indefinitely and the counter SHALL hold at 0.
REQ-026 MAIN_YELLOW SHALL last YELLOW_TICKS cycles and then move to ALLRED_A.
REQ-027 ALLRED_A SHALL last ALLRED_TICKS cycles, then move to WALK if pedPending is 1, else to SIDE_GREEN.
REQ-028 WALK SHALL last WALK_TICKS cycles, then move to SIDE_GREEN if sideCarPresent is 1 at exit, else directly to MAIN_GREEN.
REQ-029 SIDE_GREEN SHALL last a fixed GREEN_TICKS cycles and then move to SIDE_YELLOW.
REQ-030 SIDE_YELLOW SHALL last YELLOW_TICKS cycles and then move to ALLRED_B.
REQ-031 ALLRED_B SHALL last ALLRED_TICKS cycles and then move to MAIN_GREEN.
REQ-032 Internal register pedPending SHALL be set on any edge where pedReq is 1.
REQ-033 pedPending SHALL be cleared on the edge that enters WALK.
REQ-034 A pedReq on the WALK-entry edge SHALL be absorbed by that service and not re-latched.
REQ-035 A pedReq while in WALK SHALL set pedPending for the next cycle.
REQ-036 pedAck SHALL be a registered pulse, high for exactly the first cycle of WALK.
REQ-037 The two roads SHALL never be non-red in the same cycle.
REQ-038 Every change of right-of-way SHALL pass through at least ALLRED_TICKS all-red cycles.

Reset
REQ-039 Asserting rst_n low SHALL, immediately and independent of clk, force state ALLRED_B, counter = ALLRED_TICKS-1, pedPending = 0 and pedAck = 0.
REQ-040 While rst_n is low, outputs SHALL be mainCarControl = 0, sideCarControl = 0, walkSignal = 0, pedAck = 0, stateOut = 6.
REQ-041 After rst_n is released, the FSM SHALL spend ALLRED_TICKS cycles in ALLRED_B and then enter MAIN_GREEN.
REQ-042 Reset asserted mid-operation SHALL discard all pending requests and timing.

Verification (default parameters)
REQ-043 Reset then release with no inputs -> 1 cycle of stateOut = 6, then main = 2 and side = 0 held for 50 or more cycles.
REQ-044 sideCarPresent = 1 on MAIN_GREEN entry -> main 2 for 4 cycles, 1 for 2, all-red 1, side 2 for 6, 1 for 2, all-red 1, then main 2.
REQ-045 One-cycle pedReq during MAIN_GREEN -> after yellow and all-red: pedAck = 1 for 1 cycle, walkSignal = 1 for 3 cycles, both roads 0, then main 2.
REQ-046 pedReq and sideCarPresent both held at 1 -> WALK for 3 cycles precedes SIDE_GREEN for 6 cycles; code 3 never appears.
REQ-047 rst_n driven low mid-SIDE_GREEN between clock edges -> side = 0 and stateOut = 6 before the next edge; the pending pedReq is lost.
REQ-048 Every run -> assertion that main and side are never both non-zero in the same cycle holds.
